// File: rtl/num_check.sv
// num_check: AXI-Stream packet sink that checks a num_gen traffic stream.
// Each accepted flit is compared against a local copy of the generator's
// 8-bit LFSR, against the expected destination and against TLAST framing.
// Packet/error counters, a sticky error flag and a done flag summarise a run.
module num_check #(
    parameter int                  TDATAW       = 32,
    parameter int                  TDESTW       = 4,
    parameter int                  LFSR_DW      = 8,
    parameter logic [LFSR_DW-1:0]  LFSR_DEFAULT = 8'h01,
    parameter int                  NUM_PACKETS  = 16,
    parameter int                  PKT_LEN      = 4,
    parameter int                  MY_DEST      = 0,
    parameter int                  STALL_PERIOD = 0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic              AXIS_S_TVALID,
    output logic              AXIS_S_TREADY,
    input  logic [TDATAW-1:0] AXIS_S_TDATA,
    input  logic              AXIS_S_TLAST,
    input  logic [TDESTW-1:0] AXIS_S_TDEST,
    output logic [15:0]       PKT_CNT,
    output logic [15:0]       ERR_CNT,
    output logic              ERROR,
    output logic              DONE
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int                IDXW       = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [IDXW-1:0]   IDX_LAST   = IDXW'(PKT_LEN - 1);
    localparam logic [IDXW-1:0]   IDX_ONE    = IDXW'(1);
    localparam bit                STALL_EN   = (STALL_PERIOD >= 2);
    localparam int                SW         = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
    localparam logic [SW-1:0]     STALL_LAST = SW'(STALL_PERIOD - 1);
    localparam logic [SW-1:0]     STALL_ONE  = SW'(1);
    localparam logic [15:0]       NUM_PKT_C  = 16'(NUM_PACKETS);
    localparam logic [TDESTW-1:0] MY_DEST_C  = TDESTW'(MY_DEST);

    // Fibonacci LFSR step shared with the generator: taps 7,5,4,3.
    function automatic logic [LFSR_DW-1:0] lfsr_step(input logic [LFSR_DW-1:0] q);
        return {q[LFSR_DW-2:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    endfunction

    state_t              state_r, state_next_s;
    logic [LFSR_DW-1:0]  lfsr_r, lfsr_next_s;
    logic [IDXW-1:0]     idx_r, idx_next_s;
    logic [SW-1:0]       stall_r, stall_next_s;
    logic [15:0]         pkt_cnt_r, pkt_next_s;
    logic [15:0]         err_cnt_r, err_next_s;
    logic                error_r, error_next_s;
    logic                done_r, done_next_s;
    logic                tready_r, tready_next_s;

    logic                beat_s;
    logic                err_hit_s;
    logic                mismatch_s;
    logic [TDATAW-1:0]   exp_data_s;
    logic [15:0]         pkt_inc_s;

    assign beat_s     = AXIS_S_TVALID && tready_r;
    assign exp_data_s = TDATAW'(lfsr_r);
    assign pkt_inc_s  = pkt_cnt_r + 16'd1;
    // Several failing conditions on one beat still count as a single error.
    assign mismatch_s = (AXIS_S_TDATA != exp_data_s) ||
                        (AXIS_S_TDEST != MY_DEST_C)  ||
                        (AXIS_S_TLAST != (idx_r == IDX_LAST));

    assign AXIS_S_TREADY = tready_r;
    assign PKT_CNT       = pkt_cnt_r;
    assign ERR_CNT       = err_cnt_r;
    assign ERROR         = error_r;
    assign DONE          = done_r;

    // Next-state, checking and counter logic; START overrides any beat.
    always_comb begin
        state_next_s  = state_r;
        lfsr_next_s   = lfsr_r;
        idx_next_s    = idx_r;
        stall_next_s  = stall_r;
        pkt_next_s    = pkt_cnt_r;
        err_next_s    = err_cnt_r;
        error_next_s  = error_r;
        done_next_s   = done_r;
        err_hit_s     = 1'b0;
        tready_next_s = 1'b0;

        if (START) begin
            state_next_s = ST_RUN;
            lfsr_next_s  = LFSR_DEFAULT;
            idx_next_s   = {IDXW{1'b0}};
            stall_next_s = {SW{1'b0}};
            pkt_next_s   = 16'd0;
            err_next_s   = 16'd0;
            error_next_s = 1'b0;
            done_next_s  = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_next_s = ST_IDLE;
                end
                ST_RUN: begin
                    // The stall counter runs on every RUN cycle, beat or not.
                    if (STALL_EN && (stall_r != STALL_LAST)) begin
                        stall_next_s = stall_r + STALL_ONE;
                    end else begin
                        stall_next_s = {SW{1'b0}};
                    end
                    if (beat_s) begin
                        // The LFSR advances even on a bad beat: no resync.
                        lfsr_next_s = lfsr_step(lfsr_r);
                        err_hit_s   = mismatch_s;
                        if (AXIS_S_TLAST) begin
                            idx_next_s = {IDXW{1'b0}};
                            pkt_next_s = pkt_inc_s;
                            if (pkt_inc_s == NUM_PKT_C) begin
                                state_next_s = ST_DONE;
                                done_next_s  = 1'b1;
                            end else begin
                                state_next_s = ST_RUN;
                            end
                        end else if (idx_r != IDX_LAST) begin
                            idx_next_s = idx_r + IDX_ONE;
                        end else begin
                            idx_next_s = idx_r;
                        end
                    end else begin
                        lfsr_next_s = lfsr_r;
                    end
                end
                ST_DONE: begin
                    // Anything arriving after the final packet is an overrun.
                    err_hit_s = beat_s;
                end
                default: begin
                    state_next_s = ST_IDLE;
                end
            endcase

            if (err_hit_s) begin
                error_next_s = 1'b1;
                if (err_cnt_r != 16'hFFFF) begin
                    err_next_s = err_cnt_r + 16'd1;
                end else begin
                    err_next_s = err_cnt_r;
                end
            end else begin
                error_next_s = error_r;
            end
        end

        // TREADY is registered, so it is derived from the next state.
        case (state_next_s)
            ST_RUN:  tready_next_s = !(STALL_EN && (stall_next_s == STALL_LAST));
            ST_DONE: tready_next_s = 1'b1;
            default: tready_next_s = 1'b0;
        endcase
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r   <= ST_IDLE;
            lfsr_r    <= LFSR_DEFAULT;
            idx_r     <= {IDXW{1'b0}};
            stall_r   <= {SW{1'b0}};
            pkt_cnt_r <= 16'd0;
            err_cnt_r <= 16'd0;
            error_r   <= 1'b0;
            done_r    <= 1'b0;
            tready_r  <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            lfsr_r    <= lfsr_next_s;
            idx_r     <= idx_next_s;
            stall_r   <= stall_next_s;
            pkt_cnt_r <= pkt_next_s;
            err_cnt_r <= err_next_s;
            error_r   <= error_next_s;
            done_r    <= done_next_s;
            tready_r  <= tready_next_s;
        end
    end

endmodule

// File: tb/tb_num_check.sv
// Bench for num_check: a vector table covering clean, corrupted, framing,
// destination and overrun traffic, plus hand-written sequences for
// backpressure (second instance with STALL_PERIOD=3) and reset mid-run.
module tb_num_check;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;

    logic        start = 1'b0, valid = 1'b0, last = 1'b0;
    logic [31:0] data = 32'd0;
    logic [3:0]  dest = 4'd0;
    logic        tready, error_f, done_f;
    logic [15:0] pkt_cnt, err_cnt;

    logic        bp_start = 1'b0, bp_valid = 1'b0, bp_last = 1'b0;
    logic [31:0] bp_data = 32'd0;
    logic [3:0]  bp_dest = 4'd0;
    logic        bp_tready, bp_error, bp_done;
    logic [15:0] bp_pkt, bp_err;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    num_check #(.NUM_PACKETS(2), .PKT_LEN(4), .STALL_PERIOD(0)) dut (
        .CLK(CLK), .RST(RST), .START(start),
        .AXIS_S_TVALID(valid), .AXIS_S_TREADY(tready), .AXIS_S_TDATA(data),
        .AXIS_S_TLAST(last), .AXIS_S_TDEST(dest),
        .PKT_CNT(pkt_cnt), .ERR_CNT(err_cnt), .ERROR(error_f), .DONE(done_f)
    );

    num_check #(.NUM_PACKETS(2), .PKT_LEN(4), .STALL_PERIOD(3)) dut_bp (
        .CLK(CLK), .RST(RST), .START(bp_start),
        .AXIS_S_TVALID(bp_valid), .AXIS_S_TREADY(bp_tready), .AXIS_S_TDATA(bp_data),
        .AXIS_S_TLAST(bp_last), .AXIS_S_TDEST(bp_dest),
        .PKT_CNT(bp_pkt), .ERR_CNT(bp_err), .ERROR(bp_error), .DONE(bp_done)
    );

    typedef struct {
        logic        start;
        logic        valid;
        logic [7:0]  data;
        logic        last;
        logic [3:0]  dest;
        logic [15:0] exp_pkt;
        logic [15:0] exp_err;
        logic        exp_error;
        logic        exp_done;
        logic        exp_tready;
    } vec_t;

    vec_t vq[$];

    // LFSR sequence from seed 0x01 with taps 7,5,4,3, worked by hand.
    logic [7:0] seq [0:7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic s, input logic v, input logic [7:0] d, input logic l,
                       input logic [3:0] ds, input logic [15:0] ep, input logic [15:0] ee,
                       input logic eer, input logic edn, input logic etr);
        vec_t x;
        x.start = s; x.valid = v; x.data = d; x.last = l; x.dest = ds;
        x.exp_pkt = ep; x.exp_err = ee; x.exp_error = eer; x.exp_done = edn; x.exp_tready = etr;
        vq.push_back(x);
    endtask

    // Drive one cycle at the falling edge; outputs are sampled 1 time unit after the rising edge.
    task automatic drive(input logic s, input logic v, input logic [7:0] d, input logic l,
                         input logic [3:0] ds);
        @(negedge CLK);
        start = s; valid = v; data = {24'h000000, d}; last = l; dest = ds;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int k;
        logic rdy;

        seq[0] = 8'h01; seq[1] = 8'h02; seq[2] = 8'h04; seq[3] = 8'h08;
        seq[4] = 8'h11; seq[5] = 8'h23; seq[6] = 8'h47; seq[7] = 8'h8E;

        // ---- vector table: {start,valid,data,last,dest} -> {pkt,err,error,done,tready}
        // clean run
        add(1'b1, 1'b0, 8'h00, 1'b0, 4'd0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b1, 8'h01, 1'b0, 4'd0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b1, 8'h02, 1'b0, 4'd0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b1, 8'h04, 1'b0, 4'd0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b1, 8'h08, 1'b1, 4'd0, 16'd1, 16'd0, 1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b1, 8'h11, 1'b0, 4'd0, 16'd1, 16'd0, 1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b1, 8'h23, 1'b0, 4'd0, 16'd1, 16'd0, 1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b1, 8'h47, 1'b0, 4'd0, 16'd1, 16'd0, 1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b1, 8'h8E, 1'b1, 4'd0, 16'd2, 16'd0, 1'b0, 1'b1, 1'b1);
        add(1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 16'd2, 16'd0, 1'b0, 1'b1, 1'b1);
        // overrun: three beats in DONE
        add(1'b0, 1'b1, 8'h55, 1'b0, 4'd0, 16'd2, 16'd1, 1'b1, 1'b1, 1'b1);
        add(1'b0, 1'b1, 8'h55, 1'b1, 4'd0, 16'd2, 16'd2, 1'b1, 1'b1, 1'b1);
        add(1'b0, 1'b1, 8'h55, 1'b0, 4'd0, 16'd2, 16'd3, 1'b1, 1'b1, 1'b1);
        // START together with a valid beat: beat dropped, everything cleared
        add(1'b1, 1'b1, 8'h01, 1'b0, 4'd0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1);
        // data corruption on flit 2, rest clean
        add(1'b0, 1'b1, 8'h01, 1'b0, 4'd0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b1, 8'h03, 1'b0, 4'd0, 16'd0, 16'd1, 1'b1, 1'b0, 1'b1);
        add(1'b0, 1'b1, 8'h04, 1'b0, 4'd0, 16'd0, 16'd1, 1'b1, 1'b0, 1'b1);
        add(1'b0, 1'b1, 8'h08, 1'b1, 4'd0, 16'd1, 16'd1, 1'b1, 1'b0, 1'b1);
        add(1'b0, 1'b1, 8'h11, 1'b0, 4'd0, 16'd1, 16'd1, 1'b1, 1'b0, 1'b1);
        add(1'b0, 1'b1, 8'h23, 1'b0, 4'd0, 16'd1, 16'd1, 1'b1, 1'b0, 1'b1);
        add(1'b0, 1'b1, 8'h47, 1'b0, 4'd0, 16'd1, 16'd1, 1'b1, 1'b0, 1'b1);
        add(1'b0, 1'b1, 8'h8E, 1'b1, 4'd0, 16'd2, 16'd1, 1'b1, 1'b1, 1'b1);
        // framing: early TLAST on flit 2, then a clean 4-flit packet
        add(1'b1, 1'b0, 8'h00, 1'b0, 4'd0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b1, 8'h01, 1'b0, 4'd0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b1, 8'h02, 1'b1, 4'd0, 16'd1, 16'd1, 1'b1, 1'b0, 1'b1);
        add(1'b0, 1'b1, 8'h04, 1'b0, 4'd0, 16'd1, 16'd1, 1'b1, 1'b0, 1'b1);
        add(1'b0, 1'b1, 8'h08, 1'b0, 4'd0, 16'd1, 16'd1, 1'b1, 1'b0, 1'b1);
        add(1'b0, 1'b1, 8'h11, 1'b0, 4'd0, 16'd1, 16'd1, 1'b1, 1'b0, 1'b1);
        add(1'b0, 1'b1, 8'h23, 1'b1, 4'd0, 16'd2, 16'd1, 1'b1, 1'b1, 1'b1);
        // wrong dest, double fault counted once, missing TLAST, index saturation
        add(1'b1, 1'b0, 8'h00, 1'b0, 4'd0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b1, 8'h01, 1'b0, 4'd1, 16'd0, 16'd1, 1'b1, 1'b0, 1'b1);
        add(1'b0, 1'b1, 8'hFF, 1'b0, 4'd2, 16'd0, 16'd2, 1'b1, 1'b0, 1'b1);
        add(1'b0, 1'b1, 8'h04, 1'b0, 4'd0, 16'd0, 16'd2, 1'b1, 1'b0, 1'b1);
        add(1'b0, 1'b1, 8'h08, 1'b0, 4'd0, 16'd0, 16'd3, 1'b1, 1'b0, 1'b1);
        add(1'b0, 1'b1, 8'h11, 1'b1, 4'd0, 16'd1, 16'd3, 1'b1, 1'b0, 1'b1);
        add(1'b0, 1'b1, 8'h23, 1'b0, 4'd0, 16'd1, 16'd3, 1'b1, 1'b0, 1'b1);

        // ---- reset state (TVALID held high must not be accepted)
        valid = 1'b1; data = 32'h00000001;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_tready", 32'(tready), 32'd0);
        chk("rst_pkt", 32'(pkt_cnt), 32'd0);
        chk("rst_err", 32'(err_cnt), 32'd0);
        chk("rst_error", 32'(error_f), 32'd0);
        chk("rst_done", 32'(done_f), 32'd0);
        chk("rst_bp_tready", 32'(bp_tready), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        drive(1'b0, 1'b1, 8'h01, 1'b0, 4'd0);
        chk("idle_tready", 32'(tready), 32'd0);
        chk("idle_pkt_err", {pkt_cnt, err_cnt}, 32'd0);

        // ---- table
        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].start, vq[i].valid, vq[i].data, vq[i].last, vq[i].dest);
            chk($sformatf("v%0d_pkt", i), 32'(pkt_cnt), 32'(vq[i].exp_pkt));
            chk($sformatf("v%0d_err", i), 32'(err_cnt), 32'(vq[i].exp_err));
            chk($sformatf("v%0d_error", i), 32'(error_f), 32'(vq[i].exp_error));
            chk($sformatf("v%0d_done", i), 32'(done_f), 32'(vq[i].exp_done));
            chk($sformatf("v%0d_tready", i), 32'(tready), 32'(vq[i].exp_tready));
        end

        // ---- backpressure: STALL_PERIOD=3, TVALID held high.
        // TREADY goes 1,1,0 from the cycle after START; the eight flits land in
        // the first 11 cycles of a 12-cycle window and DONE shows in the 12th.
        @(negedge CLK);
        bp_start = 1'b1;
        @(posedge CLK);
        #1;
        chk("bp_start_tready", 32'(bp_tready), 32'd1);
        k = 0;
        for (int c = 0; c < 11; c++) begin
            @(negedge CLK);
            bp_start = 1'b0;
            bp_valid = 1'b1;
            bp_data  = {24'h000000, seq[k & 7]};
            bp_last  = (k == 3) || (k == 7);
            chk($sformatf("bp_tready_c%0d", c), 32'(bp_tready), (c % 3 == 2) ? 32'd0 : 32'd1);
            rdy = bp_tready;
            @(posedge CLK);
            #1;
            if (rdy) k++;
        end
        chk("bp_accepted", 32'(k), 32'd8);
        chk("bp_pkt", 32'(bp_pkt), 32'd2);
        chk("bp_err", 32'(bp_err), 32'd0);
        chk("bp_done", 32'(bp_done), 32'd1);
        @(negedge CLK);
        bp_valid = 1'b0;
        chk("bp_done_tready", 32'(bp_tready), 32'd1);

        // ---- reset mid-run: three flits (one bad), then RST
        drive(1'b1, 1'b0, 8'h00, 1'b0, 4'd0);
        drive(1'b0, 1'b1, 8'h01, 1'b0, 4'd0);
        drive(1'b0, 1'b1, 8'h99, 1'b0, 4'd0);
        drive(1'b0, 1'b1, 8'h04, 1'b0, 4'd0);
        chk("mid_err_before", 32'(err_cnt), 32'd1);
        @(negedge CLK);
        RST = 1'b1; data = 32'h00000008; last = 1'b1;
        @(posedge CLK);
        #1;
        chk("mid_tready", 32'(tready), 32'd0);
        chk("mid_pkt", 32'(pkt_cnt), 32'd0);
        chk("mid_err", 32'(err_cnt), 32'd0);
        chk("mid_error", 32'(error_f), 32'd0);
        chk("mid_done", 32'(done_f), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        drive(1'b0, 1'b1, 8'h01, 1'b1, 4'd0);
        drive(1'b0, 1'b1, 8'h01, 1'b1, 4'd0);
        chk("mid_idle_tready", 32'(tready), 32'd0);
        chk("mid_idle_pkt", 32'(pkt_cnt), 32'd0);
        // a fresh START after reset begins from the seed again
        drive(1'b1, 1'b0, 8'h00, 1'b0, 4'd0);
        chk("mid_restart_tready", 32'(tready), 32'd1);
        drive(1'b0, 1'b1, 8'h01, 1'b0, 4'd0);
        chk("mid_restart_err", 32'(err_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
